// File: rtl/rr_token_arbiter.sv
// -----------------------------------------------------------------------------
// rr_token_arbiter
//   Centralized round-robin arbiter granting one shared resource to N clients
//   through a per-client four-phase req/ack handshake. Idle clients are skipped
//   within a single cycle, every ownership change is separated by one all-idle
//   cycle, and a hold-time watchdog asks a long-running owner to release.
//
// Parameters
//   N        number of requesters (2..16)
//   IDW      owner index width, at least ceil(log2(N))
//   HOLD_MAX grant cycles before revoke is raised; 0 disables the watchdog
//
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_req     per-client request level, held until the client releases
//   o_ack     per-client registered grant, one-hot or zero
//   o_revoke  registered release request, only set alongside the matching ack
//   o_owner   index of the current or most recent grantee
//   o_busy    high whenever any ack bit is high
// -----------------------------------------------------------------------------
module rr_token_arbiter #(
  parameter int N        = 5,
  parameter int IDW      = 3,
  parameter int HOLD_MAX = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_ack,
  output logic [N-1:0]   o_revoke,
  output logic [IDW-1:0] o_owner,
  output logic           o_busy
);

  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0]  HOLD_SAT  = CW'(HOLD_MAX);
  localparam logic [CW-1:0]  HOLD_LAST = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } StateT;

  StateT          r_state;
  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_holdCnt;
  logic [N-1:0]   r_ack;
  logic [N-1:0]   r_revoke;
  logic [IDW-1:0] r_owner;

  StateT          w_stateNext;
  logic [IDW-1:0] w_ptrNext;
  logic [CW-1:0]  w_holdCntNext;
  logic [N-1:0]   w_ackNext;
  logic [N-1:0]   w_revokeNext;
  logic [IDW-1:0] w_ownerNext;

  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [N-1:0]   w_winnerOh;
  logic           w_ownerReq;
  int             w_dist;
  int             w_bestDist;

  // Cyclic search from r_ptr: every requester computes its distance ahead of
  // the pointer and the smallest distance wins, so the whole search resolves
  // in one cycle with only constant bit indices.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_winnerOh = '0;
    w_bestDist = N;
    w_dist     = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N - int'(r_ptr));
      if (i_req[i] && (w_dist < w_bestDist)) begin
        w_bestDist    = w_dist;
        w_found       = 1'b1;
        w_winner      = IDW'(i);
        w_winnerOh    = '0;
        w_winnerOh[i] = 1'b1;
      end
    end
  end

  // r_ack is one-hot at the owner during HOLD, so masking with it picks out
  // req[owner] without a variable-width index.
  assign w_ownerReq = |(i_req & r_ack);

  // Next-state and next-output logic. Revoke is latched once the counter
  // passes HOLD_LAST and then simply held until the owner drops its request;
  // ack is never removed while the owner still requests.
  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = r_ptr;
    w_holdCntNext = r_holdCnt;
    w_ackNext     = r_ack;
    w_revokeNext  = r_revoke;
    w_ownerNext   = r_owner;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_ackNext     = w_winnerOh;
          w_revokeNext  = '0;
          w_ownerNext   = w_winner;
          w_holdCntNext = '0;
          w_stateNext   = HOLD;
        end
      end
      HOLD: begin
        if (!w_ownerReq) begin
          w_ackNext    = '0;
          w_revokeNext = '0;
          w_ptrNext    = (r_owner == LAST_IDX) ? '0 : (r_owner + 1'b1);
          w_stateNext  = GAP;
        end else begin
          if (r_holdCnt != HOLD_SAT) begin
            w_holdCntNext = r_holdCnt + 1'b1;
          end
          if ((HOLD_MAX != 0) && (r_holdCnt == HOLD_LAST)) begin
            w_revokeNext = r_ack;
          end
        end
      end
      GAP: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register; asynchronous reset drops ack/revoke immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_holdCnt <= '0;
      r_ack     <= '0;
      r_revoke  <= '0;
      r_owner   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_holdCnt <= w_holdCntNext;
      r_ack     <= w_ackNext;
      r_revoke  <= w_revokeNext;
      r_owner   <= w_ownerNext;
    end
  end

  assign o_ack    = r_ack;
  assign o_revoke = r_revoke;
  assign o_owner  = r_owner;
  assign o_busy   = |r_ack;

endmodule

// File: doc/rr_token_arbiter.md
# rr_token_arbiter

Parameterized round-robin arbiter that grants one shared resource to N requesters through a per-client four-phase req/ack handshake. It is the next-generation replacement for the distributed token-passing controller ring: one centralized block in the arbitration layer, between the clients and the shared resource. It adds single-cycle skip of idle clients, a mandatory all-idle gap between owners, and a hold-time watchdog that asks the current owner to release.

## Interface
- N, default 5: number of requesters, 2..16.
- IDW, default 3: owner index width, ≥ ceil(log2(N)).
- HOLD_MAX, default 15: grant cycles before `revoke` is asserted; 0 disables the watchdog.
- Ports:
  - clk  in  1  rising-edge clock for all state.
  - rst_n  in  1  reset, asynchronous, active-low; one clock; all state cleared while low.
  - req  in  N  request per client; level, held until released by the client.
  - ack  out  N  grant per client; registered; at most one bit high.
  - revoke  out  N  release request to the current owner; registered; only ever set together with the matching `ack` bit.
  - owner  out  IDW  index of the current or last grantee.
  - busy  out  1  high whenever any `ack` bit is high.

## Operation
- State machine: IDLE, HOLD, GAP. Internal registers:
  - ptr: next candidate index.
  - hold_cnt: saturating counter, width ceil(log2(HOLD_MAX+1)), minimum 1.
- IDLE: the block searches `req` starting at ptr and wrapping modulo N. The winner is the first set bit.
  - If any bit is set: ack[winner]←1, owner←winner, hold_cnt←0, go to HOLD.
  - Otherwise stay in IDLE with no output change.
- HOLD:
  - If req[owner] is sampled low: ack←0, revoke←0, ptr←(owner+1) mod N, go to GAP.
  - Otherwise hold_cnt increments and saturates at HOLD_MAX. When hold_cnt reaches HOLD_MAX−1 and HOLD_MAX≠0, revoke[owner]←1 and stays set until release.
- GAP: exactly one cycle with all `ack` low. Requests are not evaluated. Go to IDLE unconditionally.
- `revoke` is advisory only. The block never removes `ack` while req[owner] is high.
- Requests from non-owners during HOLD or GAP are ignored until IDLE. A request that drops before it is sampled in IDLE is never granted.
- Fairness: a client holding `req` high is granted after at most N−1 other grants.
- Invariants:
  - `ack` is one-hot or zero.
  - revoke & ~ack is always zero.
  - busy equals |ack.
  - `owner` is stable throughout HOLD.
- Reset values: ack=0, revoke=0, busy=0, owner=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant drops `ack` immediately, without waiting for a clock edge. After rst_n rises, the first grant goes to the lowest requesting index.

## Timing
- Grant latency: req[i] sampled high at edge k in IDLE, i chosen → ack[i] high after edge k; busy rises at the same edge.
- Release: req[owner] sampled low at edge e → ack low after e. The block is in GAP during the cycle after e and in IDLE after e+1.
- The earliest next grant is at edge e+2. Back-to-back owners are therefore separated by exactly one cycle with all `ack` low.
- Revoke: revoke[owner] rises HOLD_MAX cycles after ack[owner] rose. Example: HOLD_MAX=15, ack rises after edge k → revoke rises after edge k+15.
- Simultaneous requests in IDLE: lowest cyclic distance from ptr wins within the same edge; no extra cycle is spent searching.
- Owner release and a new request on the same edge: the release is taken, and the new request waits for IDLE.
- ptr wraps from N−1 to 0.

## Test plan
- Reset then single client: rst_n low for 3 cycles; req[2]=1 at edge 5 → ack=5'b00100 and owner=2 after edge 5; drop req[2] at edge 10 → ack=0 after edge 10, busy=0.
- All clients requesting continuously, each releasing 2 cycles after its grant → grant order 0,1,2,3,4,0; exactly one all-low cycle between grants; `ack` one-hot throughout.
- Skip idle clients: ptr=1, only req[4] and req[0] high → ack[4] granted first, then ack[0] after 4 releases.
- Watchdog: HOLD_MAX=15, client 3 holds `req` for 30 cycles → revoke[3] rises 15 cycles after ack[3]; ack[3] stays high until req[3] drops; revoke and ack fall together. With HOLD_MAX=0, revoke stays 0.
- Async reset mid-HOLD: client 1 owns; rst_n falls between edges → ack, revoke and busy go to 0 before the next edge; after release of reset with req[1] and req[3] high → client 1 is granted.
- Random 10k-cycle run, random req toggling that obeys the handshake → checker confirms the invariants, no starvation beyond N−1 grants, and a one-cycle gap on every ownership change.
